// File: rtl/rotation_ctrl_if.sv
// Button inputs and display-mux control outputs of rotation_ctrl.
// master = stimulus/button side, slave = the controller itself.
interface rotation_ctrl_if;
    logic btn_run;
    logic btn_dir;
    logic en;
    logic cw;
    logic run_pulse;
    logic dir_pulse;
    logic run_db;
    logic dir_db;

    modport master (
        output btn_run, btn_dir,
        input  en, cw, run_pulse, dir_pulse, run_db, dir_db
    );

    modport slave (
        input  btn_run, btn_dir,
        output en, cw, run_pulse, dir_pulse, run_db, dir_db
    );
endinterface

// File: rtl/rotation_ctrl.sv
// Run/pause and direction button conditioning: sync, debounce, press-edge toggle of en/cw.
// Press to pulse/toggle: 2**DB_N+4 clk edges after the raw rise; release clears db in the same time.
module rotation_ctrl #(
    parameter int DB_N = 20
) (
    input  logic             clk,
    input  logic             rst,
    rotation_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L} db_state_e;

    localparam logic [DB_N-1:0] CNT_MAX = '1;

    // Index 0 = run button, index 1 = direction button.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       s_q;
    db_state_e        state_q [2];
    db_state_e        state_d [2];
    logic [DB_N-1:0]  cnt_q   [2];
    logic [DB_N-1:0]  cnt_d   [2];
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_d;
    logic             en_q;
    logic             en_d;
    logic             cw_q;
    logic             cw_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            s_q     <= '0;
            pulse_q <= '0;
            en_q    <= 1'b0;
            cw_q    <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= {bus.btn_dir, bus.btn_run};
            sync2_q <= sync1_q;
            s_q     <= sync2_q;
            pulse_q <= pulse_d;
            en_q    <= en_d;
            cw_q    <= cw_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // The counter exits its check state at terminal count, so it never wraps.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                LOW: begin
                    if (s_q[i]) begin
                        state_d[i] = CHK_H;
                        cnt_d[i]   = '0;
                    end
                end
                CHK_H: begin
                    if (!s_q[i]) begin
                        state_d[i] = LOW;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = HIGH;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s_q[i]) begin
                        state_d[i] = CHK_L;
                        cnt_d[i]   = '0;
                    end
                end
                CHK_L: begin
                    if (s_q[i]) begin
                        state_d[i] = HIGH;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = LOW;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = LOW;
            endcase
        end
        en_d = en_q ^ pulse_d[0];
        cw_d = cw_q ^ pulse_d[1];
    end

    assign bus.en        = en_q;
    assign bus.cw        = cw_q;
    assign bus.run_pulse = pulse_q[0];
    assign bus.dir_pulse = pulse_q[1];
    assign bus.run_db    = (state_q[0] == HIGH) || (state_q[0] == CHK_L);
    assign bus.dir_db    = (state_q[1] == HIGH) || (state_q[1] == CHK_L);

endmodule

// File: tb/tb_rotation_ctrl.sv
// Directed bench for rotation_ctrl with DB_N=4: presses qualify 20 edges after the raw rise.
module tb_rotation_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   run_cnt;
    int   dir_cnt;
    int   snap;

    rotation_ctrl_if bus ();

    rotation_ctrl #(.DB_N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count pulse-high cycles so "exactly one pulse" can be checked across a whole press.
    initial begin
        run_cnt = 0;
        dir_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.run_pulse === 1'b1) run_cnt++;
            if (bus.dir_pulse === 1'b1) dir_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        step(n);
        rst = 1'b1;
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        rst     = 1'b0;
        bus.btn_run = 1'b1;
        bus.btn_dir = 1'b1;

        // Reset state with both buttons held.
        step(5);
        chk("rst_en", bus.en, 1'b0);
        chk("rst_cw", bus.cw, 1'b1);
        chk("rst_run_pulse", bus.run_pulse, 1'b0);
        chk("rst_dir_pulse", bus.dir_pulse, 1'b0);
        chk("rst_run_db", bus.run_db, 1'b0);
        chk("rst_dir_db", bus.dir_db, 1'b0);
        rst = 1'b1;
        step(19);
        chk("held_e19_en", bus.en, 1'b0);
        chk("held_e19_run_db", bus.run_db, 1'b0);
        step(1);
        chk("held_e20_run_pulse", bus.run_pulse, 1'b1);
        chk("held_e20_dir_pulse", bus.dir_pulse, 1'b1);
        chk("held_e20_en", bus.en, 1'b1);
        chk("held_e20_cw", bus.cw, 1'b0);
        chk("held_e20_run_db", bus.run_db, 1'b1);
        chk("held_e20_dir_db", bus.dir_db, 1'b1);
        step(1);
        chk("held_e21_run_pulse", bus.run_pulse, 1'b0);
        chk("held_e21_dir_pulse", bus.dir_pulse, 1'b0);
        bus.btn_run = 1'b0;
        bus.btn_dir = 1'b0;
        step(25);
        chk("rel_run_db", bus.run_db, 1'b0);
        chk("rel_en", bus.en, 1'b1);
        chk("rel_cw", bus.cw, 1'b0);

        // Single run press held 40 cycles.
        do_reset(2);
        chk("rst2_en", bus.en, 1'b0);
        chk("rst2_cw", bus.cw, 1'b1);
        snap = run_cnt;
        bus.btn_run = 1'b1;
        step(19);
        chk("run_e19_pulse", bus.run_pulse, 1'b0);
        chk("run_e19_en", bus.en, 1'b0);
        step(1);
        chk("run_e20_pulse", bus.run_pulse, 1'b1);
        chk("run_e20_en", bus.en, 1'b1);
        step(1);
        chk("run_e21_pulse", bus.run_pulse, 1'b0);
        step(19);
        bus.btn_run = 1'b0;
        step(25);
        chk("run_rel_en", bus.en, 1'b1);
        chk("run_rel_db", bus.run_db, 1'b0);
        chk("run_one_pulse", run_cnt - snap, 1);

        // Bouncy press never stable long enough, then a clean held press.
        snap = run_cnt;
        bus.btn_run = 1'b1;
        step(10);
        bus.btn_run = 1'b0;
        step(3);
        bus.btn_run = 1'b1;
        step(10);
        bus.btn_run = 1'b0;
        step(25);
        chk("bounce_no_pulse", run_cnt - snap, 0);
        chk("bounce_en", bus.en, 1'b1);
        bus.btn_run = 1'b1;
        step(19);
        chk("b_held_e19_en", bus.en, 1'b1);
        step(1);
        chk("b_held_e20_en", bus.en, 1'b0);
        step(10);
        bus.btn_run = 1'b0;
        step(25);
        chk("b_held_one_pulse", run_cnt - snap, 1);

        // Direction toggles independent of en.
        bus.btn_dir = 1'b1;
        step(20);
        chk("dir1_pulse", bus.dir_pulse, 1'b1);
        chk("dir1_cw", bus.cw, 1'b0);
        chk("dir1_en", bus.en, 1'b0);
        bus.btn_dir = 1'b0;
        step(25);
        bus.btn_run = 1'b1;
        step(20);
        chk("dir_run_en", bus.en, 1'b1);
        bus.btn_run = 1'b0;
        step(25);
        bus.btn_dir = 1'b1;
        step(20);
        chk("dir2_cw", bus.cw, 1'b1);
        chk("dir2_en", bus.en, 1'b1);
        bus.btn_dir = 1'b0;
        step(25);

        // Both buttons rise together.
        do_reset(2);
        bus.btn_run = 1'b1;
        bus.btn_dir = 1'b1;
        step(20);
        chk("both_run_pulse", bus.run_pulse, 1'b1);
        chk("both_dir_pulse", bus.dir_pulse, 1'b1);
        chk("both_en", bus.en, 1'b1);
        chk("both_cw", bus.cw, 1'b0);
        bus.btn_dir = 1'b0;

        // Reset mid-qualification: release, hold run, expect one clean toggle.
        bus.btn_run = 1'b0;
        step(25);
        bus.btn_run = 1'b1;
        step(14);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_en", bus.en, 1'b0);
        chk("midrst_cw", bus.cw, 1'b1);
        chk("midrst_run_db", bus.run_db, 1'b0);
        step(3);
        snap = run_cnt;
        rst = 1'b1;
        step(19);
        chk("midrst_e19_en", bus.en, 1'b0);
        step(1);
        chk("midrst_e20_en", bus.en, 1'b1);
        chk("midrst_e20_pulse", bus.run_pulse, 1'b1);
        step(10);
        chk("midrst_held_en", bus.en, 1'b1);
        bus.btn_run = 1'b0;
        step(25);
        chk("midrst_one_pulse", run_cnt - snap, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
